// File: rtl/shifter_pkg.sv
// Shared shifter definitions: default datapath width, shift-amount width and FSM states.
// No logic of its own; imported by the iterative shifter.
// Types and constants only, no timing or flow-control behaviour.
package shifter_pkg;

    localparam int SHIFTER_N  = 32;
    localparam int SHIFTER_CW = $clog2(SHIFTER_N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_left_iterative.sv
// Iterative logical left shifter: one bit position per clock, zero-filled from the LSB.
// Latency: shamt+1 cycles from the accept edge to the first cycle out_valid is high.
// Backpressure: one request in flight; in_ready only in IDLE; the result holds in DONE until out_ready.
module shift_left_iterative
    import shifter_pkg::*;
#(
    parameter int N = SHIFTER_N
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in,
    input  logic [$clog2(N)-1:0] shamt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out,
    output logic                 busy
);

    localparam int CW = $clog2(N);

    state_t          state_q;
    state_t          state_d;
    logic [N-1:0]    data_q;
    logic [CW-1:0]   count_q;

    // Next state: leave IDLE on accept (straight to DONE for a zero shift),
    // finish SHIFT on the last count, return from DONE once the result is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // count_q is never 0 here; the <= also guards against a stuck SHIFT.
                if (count_q <= CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus the inline shift register and down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in;
                        count_q <= shamt;
                    end
                end
                SHIFT: begin
                    data_q <= {data_q[N-2:0], 1'b0};
                    if (count_q != '0) begin
                        count_q <= count_q - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and status outputs decoded from the state alone.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: begin
            end
        endcase
    end

    assign out = data_q;

endmodule

// File: doc/shift_left_iterative.md
SHIFT_LEFT_ITERATIVE -- requirements
Module: shift_left_iterative

Interface
REQ-001 SHALL have parameter N, default 32, data width; only N=32 is required to work.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request carries a valid operand and shift amount.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port in  input  N  operand to shift left logically.
REQ-007 SHALL have port shamt  input  $clog2(N)  shift amount, 0 to N-1.
REQ-008 SHALL have port out_valid  output  1  result is present on out.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port out  output  N  result, in << shamt, zero-filled from LSB.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL assert in_ready only in IDLE, so at most one request is in flight.
REQ-014 Accept occurs when in_valid && in_ready; on accept SHALL load data_reg=in and count_reg=shamt.
REQ-015 On accept with shamt==0, SHALL go IDLE->DONE; otherwise IDLE->SHIFT.
REQ-016 In SHIFT, each cycle SHALL set data_reg={data_reg[N-2:0],1'b0} and count_reg=count_reg-1.
REQ-017 In SHIFT, when count_reg==1 the final shift SHALL occur and the state SHALL go SHIFT->DONE.
REQ-018 Latency SHALL be exactly shamt+1 cycles from the accept edge to the first cycle out_valid is high.
REQ-019 In DONE, SHALL hold out_valid=1 and out=data_reg stable until out_ready is high.
REQ-020 On DONE with out_ready, SHALL go DONE->IDLE; in_ready SHALL rise on the following cycle, with no same-cycle re-accept.
REQ-021 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-022 out SHALL be driven from data_reg at all times; its value is meaningful only while out_valid is high.
REQ-023 Bits shifted past bit N-1 SHALL be discarded; no overflow flag.
REQ-024 count_reg SHALL be $clog2(N) bits wide, and its arithmetic SHALL never underflow.

Reset
REQ-025 While rst is high, state SHALL be IDLE, data_reg=0, count_reg=0, out_valid=0, busy=0, in_ready=1, out=0.
REQ-026 Reset asserted mid-SHIFT or mid-DONE SHALL immediately discard the in-flight operation, with no result emitted.
REQ-027 After rst deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-028 SHALL place the state enum type (IDLE, SHIFT, DONE) in shared package shifter_pkg, alongside existing shifter constants.
REQ-029 SHALL have no sub-module; the counter and shift register SHALL be inline in one always_ff block.
REQ-030 Output decode (in_ready, out_valid, busy) SHALL be in an always_comb block driven by state only.

Verification
REQ-031 Stimulus: in=32'h0000_0001, shamt=31, out_ready=1 -> out_valid after 32 cycles, out=32'h8000_0000.
REQ-032 Stimulus: in=32'hDEAD_BEEF, shamt=0 -> out_valid on the cycle after accept, out=32'hDEAD_BEEF.
REQ-033 Stimulus: in=32'hFFFF_FFFF, shamt=4, out_ready held low 10 cycles -> out=32'hFFFF_FFF0 held stable with out_valid=1, in_ready=0 throughout; single-cycle pulse of out_ready -> IDLE next cycle.
REQ-034 Stimulus: rst pulsed 3 cycles after accepting shamt=20 -> out_valid never rises for that request, state returns to IDLE, and a following request in=1, shamt=1 yields out=2.
REQ-035 Stimulus: in_valid held high continuously with back-to-back requests -> each accept is separated by shamt+2 cycles minimum, and no request is lost or duplicated.
REQ-036 Stimulus: random in/shamt, 1000 requests, random out_ready -> every result equals in<<shamt against the reference model.
